// File: rtl/i2s_rx_v_if.sv
// ----------------------------------------------------------------------------
// i2s_rx_v_if
//   Bundles the I2S receiver's pin side and its sample side into one interface.
//   master : the receiver (samples the pins, drives o_valid/o_data/o_err)
//   slave  : the environment (drives the pins, consumes the samples)
// Signals
//   i_sclk, i_lrck, i_sdata : I2S pins, asynchronous to the receiver clock
//   o_valid                 : one-clk pulse, o_data holds a new sample
//   o_data [OUT_WIDTH]      : two's-complement sample, held between pulses
//   o_err                   : one-clk pulse, short frame discarded
// ----------------------------------------------------------------------------
interface i2s_rx_v_if #(
  parameter int OUT_WIDTH = 16
);
  logic                 i_sclk;
  logic                 i_lrck;
  logic                 i_sdata;
  logic                 o_valid;
  logic [OUT_WIDTH-1:0] o_data;
  logic                 o_err;

  modport master (
    input  i_sclk, i_lrck, i_sdata,
    output o_valid, o_data, o_err
  );

  modport slave (
    output i_sclk, i_lrck, i_sdata,
    input  o_valid, o_data, o_err
  );
endinterface

// File: rtl/i2s_rx_v.sv
// ----------------------------------------------------------------------------
// i2s_rx_v
//   I2S receiver front end. Oversamples the ADC's sclk/lrck/sdata pins on clk,
//   frames standard I2S words (one-bit delay after each lrck change, MSB
//   first) and emits the selected channel as valid-tagged parallel samples.
//   clk must run at least 4x sclk; sclk is never used as a clock.
// Ports
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : i2s_rx_v_if.master (pins in; o_valid/o_data/o_err out)
// ----------------------------------------------------------------------------
module i2s_rx_v #(
  parameter int SAMPLE_WIDTH = 24,  // bits per I2S word, MSB first
  parameter int OUT_WIDTH    = 16,  // top OUT_WIDTH bits kept, <= SAMPLE_WIDTH
  parameter int CHANNEL      = 0,   // 0 = left (lrck low), 1 = right
  parameter int SYNC_STAGES  = 2    // >= 2 flops per pin
) (
  input  logic       clk,
  input  logic       rst,
  i2s_rx_v_if.master bus
);

  localparam int CW = $clog2(SAMPLE_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;

  // Pin synchronisers and sclk rising-edge detect
  logic [SYNC_STAGES-1:0] sclk_sync, lrck_sync, sdata_sync;
  logic                   sclk_prev;
  logic                   sclk_s, lrck_s, sdata_s, tick;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign lrck_s  = lrck_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];
  assign tick    = sclk_s & ~sclk_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync  <= '0;
      lrck_sync  <= '0;
      sdata_sync <= '0;
      sclk_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value of
      // its neighbour, which is what turns this chain into a real synchroniser.
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0],  bus.i_sclk};
      lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0],  bus.i_lrck};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], bus.i_sdata};
      sclk_prev  <= sclk_s;
    end
  end

  // Framing state. The shift register holds only the bits received so far;
  // the LSB is taken straight from sdata_s on the completing tick.
  state_t                  state_q, state_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    chan_q, chan_d;
  logic                    lrck_prev_q, lrck_prev_d;
  logic                    primed_q, primed_d;
  logic [SAMPLE_WIDTH-2:0] shreg_q, shreg_d;
  logic [SAMPLE_WIDTH-1:0] word;
  logic                    lr_edge, capture, short_frame;

  assign word    = {shreg_q, sdata_s};
  // primed masks the first tick after reset, so a word already in flight
  // cannot be mistaken for a frame start.
  assign lr_edge = tick && primed_q && (lrck_s != lrck_prev_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      chan_q      <= 1'b0;
      lrck_prev_q <= 1'b0;
      primed_q    <= 1'b0;
      // NOTE: the shift register is cleared although every word overwrites
      // it, so nothing from before reset can ever leak into a sample.
      shreg_q     <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      chan_q      <= chan_d;
      lrck_prev_q <= lrck_prev_d;
      primed_q    <= primed_d;
      shreg_q     <= shreg_d;
    end
  end

  always_comb begin
    // NOTE: every target gets its hold value first; a path that leaves one
    // unassigned would otherwise infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    chan_d      = chan_q;
    lrck_prev_d = lrck_prev_q;
    primed_d    = primed_q;
    shreg_d     = shreg_q;
    if (tick) begin
      lrck_prev_d = lrck_s;
      primed_d    = 1'b1;
      if (lr_edge) begin
        // An edge always restarts capture: its own tick is the delay slot.
        state_d   = SHIFT;
        bit_cnt_d = '0;
        chan_d    = lrck_s;
      end else if (state_q == SHIFT) begin
        shreg_d   = word[SAMPLE_WIDTH-2:0];
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) state_d = WAIT;
      end
    end
  end

  // Output decode: both strobes are mutually exclusive because lr_edge
  // suppresses completion.
  always_comb begin
    capture     = tick && (state_q == SHIFT) && !lr_edge &&
                  (bit_cnt_q == LAST_BIT) && (chan_q == 1'(CHANNEL));
    short_frame = tick && (state_q == SHIFT) && lr_edge;
  end

  logic                 valid_q, err_q;
  logic [OUT_WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= capture;
      err_q   <= short_frame;
      if (capture) data_q <= word[SAMPLE_WIDTH-1 -: OUT_WIDTH];
    end
  end

  // Truncated LSBs are intentionally dropped.
  if (OUT_WIDTH < SAMPLE_WIDTH) begin : g_trunc
    logic unused_lsbs;
    assign unused_lsbs = ^word[SAMPLE_WIDTH-OUT_WIDTH-1:0];
  end

  assign bus.o_valid = valid_q;
  assign bus.o_err   = err_q;
  assign bus.o_data  = data_q;

endmodule

// File: tb/tb_i2s_rx_v.sv
module tb_i2s_rx_v;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sclk = 1'b0, lrck = 1'b0, sdata = 1'b0;
  int   half = 4;  // clk cycles per sclk phase

  always #5 clk = ~clk;

  i2s_rx_v_if #(.OUT_WIDTH(16)) if0 ();
  i2s_rx_v_if #(.OUT_WIDTH(16)) if1 ();

  assign if0.i_sclk = sclk;  assign if0.i_lrck = lrck;  assign if0.i_sdata = sdata;
  assign if1.i_sclk = sclk;  assign if1.i_lrck = lrck;  assign if1.i_sdata = sdata;

  i2s_rx_v #(.CHANNEL(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  i2s_rx_v #(.CHANNEL(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int errors = 0;
  int checks = 0;

  // Observed side
  logic [15:0] got_q0[$], got_q1[$];
  logic [15:0] last_v0 = '0, last_v1 = '0;
  logic [15:0] hold0 = '0, hold1 = '0;
  int got_err0 = 0, got_err1 = 0, both_viol = 0, stab_viol = 0;

  always @(negedge clk) begin
    if (if0.o_valid) begin got_q0.push_back(if0.o_data); last_v0 = if0.o_data; end
    if (if1.o_valid) begin got_q1.push_back(if1.o_data); last_v1 = if1.o_data; end
    if (if0.o_err) got_err0++;
    if (if1.o_err) got_err1++;
    if ((if0.o_valid && if0.o_err) || (if1.o_valid && if1.o_err)) both_viol++;
    if (rst && !if0.o_valid && if0.o_data !== hold0) stab_viol++;
    if (rst && !if1.o_valid && if1.o_data !== hold1) stab_viol++;
    hold0 = if0.o_data;
    hold1 = if1.o_data;
  end

  // Frame-level reference model: a slot is framed when it follows a slot of
  // the other channel after the receiver has seen at least one bit; a framed
  // slot with fewer than 24 data bits raises an error at the next frame start.
  logic [15:0] exp_q0[$], exp_q1[$];
  int  exp_err = 0;
  bit  m_primed = 0, m_short = 0;
  logic m_prev_lr = 1'b0;

  task automatic model_reset();
    m_primed = 0;
    m_short  = 0;
  endtask

  task automatic model_slot(input logic lr, input logic [23:0] w, input int n);
    if (m_primed && lr != m_prev_lr) begin
      if (m_short) exp_err++;
      if (n - 1 >= 24) begin
        if (lr == 1'b0) exp_q0.push_back(w[23:8]);
        else            exp_q1.push_back(w[23:8]);
      end
      m_short = (n - 1 < 24);
    end
    m_primed  = 1;
    m_prev_lr = lr;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i of a slot: 0 is the delay bit, 1..24 carry MSB..LSB, rest padding.
  task automatic drive_bits(input logic lr, input logic [23:0] w, input int from, input int n);
    for (int i = from; i < from + n; i++) begin
      lrck  = lr;
      sdata = (i >= 1 && i <= 24) ? w[24-i] : 1'($urandom);
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic slot(input logic lr, input logic [23:0] w, input int n);
    model_slot(lr, w, n);
    drive_bits(lr, w, 0, n);
  endtask

  task automatic checkpoint(input string tag);
    int n0, n1;
    repeat (24) @(negedge clk);
    n0 = exp_q0.size();
    n1 = exp_q1.size();
    check({tag, " count0"}, got_q0.size(), n0);
    check({tag, " count1"}, got_q1.size(), n1);
    while (got_q0.size() > 0 && exp_q0.size() > 0)
      check({tag, " data0"}, got_q0.pop_front(), exp_q0.pop_front());
    while (got_q1.size() > 0 && exp_q1.size() > 0)
      check({tag, " data1"}, got_q1.pop_front(), exp_q1.pop_front());
    got_q0 = {}; got_q1 = {}; exp_q0 = {}; exp_q1 = {};
    check({tag, " err0"}, got_err0, exp_err);
    check({tag, " err1"}, got_err1, exp_err);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " valid0"}, if0.o_valid, 0);
    check({tag, " err0"},   if0.o_err,   0);
    check({tag, " data0"},  if0.o_data,  0);
    check({tag, " valid1"}, if1.o_valid, 0);
    check({tag, " err1"},   if1.o_err,   0);
    check({tag, " data1"},  if1.o_data,  0);
  endtask

  initial begin
    logic [23:0] w;
    int n;

    // Reset state
    repeat (4) @(negedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // T1: left A5A5A5 captured by CHANNEL=0, right 123456 only by CHANNEL=1
    slot(1'b1, 24'($urandom), 32);  // primes, never framed
    slot(1'b0, 24'hA5A5A5, 32);
    slot(1'b1, 24'h123456, 32);
    checkpoint("T1");
    check("T1 last0", last_v0, 16'hA5A5);
    check("T1 last1", last_v1, 16'h1234);

    // T2: right 800001 / left 7FFFFF
    slot(1'b0, 24'($urandom), 32);
    slot(1'b1, 24'h800001, 32);
    slot(1'b0, 24'h7FFFFF, 32);
    checkpoint("T2");
    check("T2 last1", last_v1, 16'h8000);
    check("T2 last0", last_v0, 16'h7FFF);

    // T3: left word cut after 10 bits, then a full left 00FF00
    slot(1'b1, 24'($urandom), 32);
    slot(1'b0, 24'($urandom), 11);
    slot(1'b1, 24'($urandom), 32);
    slot(1'b0, 24'h00FF00, 32);
    checkpoint("T3");
    check("T3 errs", got_err0, 1);
    check("T3 last0", last_v0, 16'h00FF);

    // T4: release reset with lrck high in the middle of a right word
    rst = 1'b0;
    model_reset();
    w = 24'($urandom);
    drive_bits(1'b1, w, 0, 14);
    rst = 1'b1;
    model_slot(1'b1, w, 18);
    drive_bits(1'b1, w, 14, 18);
    checkpoint("T4 quiet");
    slot(1'b0, 24'h0C0FFE, 32);
    checkpoint("T4");
    check("T4 last0", last_v0, 16'h0C0F);

    // T5: asynchronous reset in the middle of a left word
    slot(1'b1, 24'($urandom), 32);
    slot(1'b0, 24'($urandom), 12);
    #3 rst = 1'b0;
    #1 check_outputs_zero("T5 async");
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    slot(1'b1, 24'($urandom), 32);
    slot(1'b0, 24'($urandom), 32);
    checkpoint("T5");

    // T6: 8 frames at the 4x margin, left = 0x010000*k
    half = 2;
    for (int k = 1; k <= 8; k++) begin
      slot(1'b1, 24'($urandom), 32);
      slot(1'b0, 24'(32'h010000 * k), 32);
    end
    checkpoint("T6");
    check("T6 last0", last_v0, 16'h0800);

    // T7: random words, random slot lengths including short frames
    half = 3;
    for (int k = 0; k < 12; k++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 24) : $urandom_range(25, 32);
      slot(1'(k % 2), 24'($urandom), n);
    end
    slot(1'b0, 24'($urandom), 32);
    checkpoint("T7");

    check("valid_err_overlap", both_viol, 0);
    check("data_stable", stab_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
